// File: rtl/timer_uart_periph.sv
// Memory-mapped timer and UART mailbox on the MEM-stage peripheral bus.
// Reads are combinational. Writes, timer counting and the UART buffer
// update on the rising clock edge. irqout is driven only from registered state.
module timer_uart_periph #(
    parameter logic [31:0] TH_RST = 32'hFFFF_F000,
    parameter logic [31:0] TL_RST = 32'hFFFF_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout,
    input  logic        RX_STATUS,
    input  logic [7:0]  RX_DATA,
    input  logic        TX_STATUS,
    output logic        TX_EN,
    output logic [7:0]  TX_DATA
);

    // Word offsets decoded from addr[5:2]
    localparam logic [3:0] OFF_TH   = 4'd0;
    localparam logic [3:0] OFF_TL   = 4'd1;
    localparam logic [3:0] OFF_TCON = 4'd2;
    localparam logic [3:0] OFF_TXD  = 4'd6;
    localparam logic [3:0] OFF_RXD  = 4'd7;
    localparam logic [3:0] OFF_UCON = 4'd8;

    logic [31:0] th;
    logic [31:0] tl;
    logic        tcon_en;
    logic        tcon_irq_en;
    logic        tcon_irq_stat;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ovr;
    logic        rx_irq_en;
    logic        tx_pend;

    logic [3:0]  off;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        wr_txd;
    logic        wr_ucon;
    logic        rd_rxd;
    logic        tl_max;
    logic        timer_irq;
    logic        rx_overrun;
    logic        tx_busy;
    logic        tx_start;
    logic        unused_addr;

    assign off         = addr[5:2];
    assign unused_addr = ^{addr[31:6], addr[1:0]};

    assign wr_th   = wr && (off == OFF_TH);
    assign wr_tl   = wr && (off == OFF_TL);
    assign wr_tcon = wr && (off == OFF_TCON);
    assign wr_txd  = wr && (off == OFF_TXD);
    assign wr_ucon = wr && (off == OFF_UCON);
    assign rd_rxd  = rd && (off == OFF_RXD);

    // An overflow flagged in the same cycle as a TCON write must not be lost
    assign tl_max     = (tl == 32'hFFFF_FFFF);
    assign timer_irq  = tcon_en && tl_max && tcon_irq_en;

    // A byte arriving while the previous one is unread and not being read now is an overrun
    assign rx_overrun = RX_STATUS && rx_valid && !rd_rxd;

    // tx_pend covers the gap between our strobe and uart_tx raising its busy flag
    assign tx_busy    = TX_STATUS || tx_pend;
    assign tx_start   = wr_txd && !tx_busy;

    assign irqout = tcon_irq_stat || (rx_valid && rx_irq_en);

    // Combinational read mux; rd low or unmapped offsets return zero
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            case (off)
                OFF_TH:   rdata = th;
                OFF_TL:   rdata = tl;
                OFF_TCON: rdata = {29'd0, tcon_irq_stat, tcon_irq_en, tcon_en};
                OFF_RXD:  rdata = {24'd0, rx_byte};
                OFF_UCON: rdata = {28'd0, rx_irq_en, rx_ovr, rx_valid, tx_busy};
                default:  rdata = 32'd0;
            endcase
        end
    end

    // Timer registers: bus write to TL beats counting, overflow set beats TCON clear
    always_ff @(posedge clk) begin
        if (reset) begin
            th            <= TH_RST;
            tl            <= TL_RST;
            tcon_en       <= 1'b0;
            tcon_irq_en   <= 1'b0;
            tcon_irq_stat <= 1'b0;
        end else begin
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end else if (tcon_en) begin
                tl <= tl_max ? th : tl + 32'd1;
            end
            if (wr_tcon) begin
                tcon_en     <= wdata[0];
                tcon_irq_en <= wdata[1];
            end
            if (timer_irq) begin
                tcon_irq_stat <= 1'b1;
            end else if (wr_tcon) begin
                tcon_irq_stat <= wdata[2];
            end
        end
    end

    // Receive mailbox: latest byte always kept, overrun sticky until written 1
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            rx_irq_en <= 1'b0;
        end else begin
            if (RX_STATUS) begin
                rx_byte  <= RX_DATA;
                rx_valid <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid <= 1'b0;
            end
            if (rx_overrun) begin
                rx_ovr <= 1'b1;
            end else if (wr_ucon && wdata[2]) begin
                rx_ovr <= 1'b0;
            end
            if (wr_ucon) begin
                rx_irq_en <= wdata[3];
            end
        end
    end

    // Transmit strobe: one-cycle TX_EN, writes while busy are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            TX_EN   <= 1'b0;
            TX_DATA <= 8'd0;
            tx_pend <= 1'b0;
        end else begin
            TX_EN <= tx_start;
            if (tx_start) begin
                TX_DATA <= wdata[7:0];
                tx_pend <= 1'b1;
            end else if (TX_STATUS) begin
                tx_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_uart_periph.sv
// Self-checking bench for timer_uart_periph: directed vector table,
// hand-written timer/TX corner sequences and a randomized run against a
// behavioural model of the register map.
module tb_timer_uart_periph;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;
    logic        rx_status;
    logic [7:0]  rx_data;
    logic        tx_status;
    logic        tx_en;
    logic [7:0]  tx_data;

    timer_uart_periph dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irqout(irqout), .RX_STATUS(rx_status), .RX_DATA(rx_data),
        .TX_STATUS(tx_status), .TX_EN(tx_en), .TX_DATA(tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_th, m_tl;
    logic        m_en, m_ie, m_ist;
    logic [7:0]  m_rxb;
    logic        m_rxv, m_rxo, m_rxie;
    logic        m_txen, m_txp;
    logic [7:0]  m_txd;

    logic [31:0] last_rdata;
    logic        last_irq;
    logic [7:0]  last_txd;
    int          txen_count;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rxs;
        logic [7:0]  rxd;
        logic        txs;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic rxs, input logic [7:0] rxd,
                                input logic txs, input logic [31:0] er, input logic ei);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.rxs = rxs; v.rxd = rxd;
        v.txs = txs; v.exp_rdata = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic model_reset();
        m_th = 32'hFFFF_F000; m_tl = 32'hFFFF_F000;
        m_en = 0; m_ie = 0; m_ist = 0;
        m_rxb = 0; m_rxv = 0; m_rxo = 0; m_rxie = 0;
        m_txen = 0; m_txp = 0; m_txd = 0;
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
        if (!r) return 32'd0;
        case (a[5:2])
            4'd0:    return m_th;
            4'd1:    return m_tl;
            4'd2:    return {29'd0, m_ist, m_ie, m_en};
            4'd7:    return {24'd0, m_rxb};
            4'd8:    return {28'd0, m_rxie, m_rxo, m_rxv, (tx_status | m_txp)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_ist | (m_rxv & m_rxie);
    endfunction

    // Next model state from current state and the bus/UART inputs of this cycle
    task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic rxs, input logic [7:0] rxd,
                              input logic txs);
        int          o;
        logic [31:0] th_n, tl_n;
        logic        en_n, ie_n, ist_n, overflow_irq;
        logic        rx_read, busy;
        o = int'(a[5:2]);
        th_n = m_th; tl_n = m_tl; en_n = m_en; ie_n = m_ie; ist_n = m_ist;
        overflow_irq = 0;
        if (m_en) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                tl_n = m_th;
                overflow_irq = m_ie;
            end else begin
                tl_n = m_tl + 1;
            end
        end
        if (w && o == 0) th_n = d;
        if (w && o == 1) tl_n = d;
        if (w && o == 2) begin en_n = d[0]; ie_n = d[1]; ist_n = d[2]; end
        if (overflow_irq) ist_n = 1;

        rx_read = r && o == 7;
        if (w && o == 8) begin
            m_rxie = d[3];
            if (d[2]) m_rxo = 0;
        end
        if (rxs) begin
            if (m_rxv && !rx_read) m_rxo = 1;
            m_rxb = rxd;
            m_rxv = 1;
        end else if (rx_read) begin
            m_rxv = 0;
        end

        busy = txs | m_txp;
        m_txen = 0;
        if (w && o == 6 && !busy) begin
            m_txen = 1;
            m_txd  = d[7:0];
            m_txp  = 1;
        end else if (txs) begin
            m_txp = 0;
        end
        m_th = th_n; m_tl = tl_n; m_en = en_n; m_ie = ie_n; m_ist = ist_n;
    endtask

    task automatic do_reset();
        rd = 0; wr = 0; addr = 0; wdata = 0; rx_status = 0; rx_data = 0; tx_status = 0;
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        reset = 0;
    endtask

    // One bus cycle: drive, compare at negedge, commit at posedge
    task automatic tick(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic rxs, input logic [7:0] rxd, input logic txs);
        rd = r; wr = w; addr = a; wdata = d; rx_status = rxs; rx_data = rxd; tx_status = txs;
        @(negedge clk);
        last_rdata = rdata;
        last_irq   = irqout;
        last_txd   = tx_data;
        if (tx_en === 1'b1) txen_count++;
        check("rdata_model", rdata, model_read(r, a));
        check("irq_model", 32'(irqout), 32'(model_irq()));
        check("txen_model", 32'(tx_en), 32'(m_txen));
        check("txdata_model", 32'(tx_data), 32'(m_txd));
        @(posedge clk);
        model_step(r, w, a, d, rxs, rxd, txs);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 32'd0, 32'd0, 0, 8'd0, 0);
    endtask

    initial begin
        int          j;
        logic [31:0] a, d;
        reset = 1;
        do_reset();

        // Directed vectors from reset: {rd, wr, addr, wdata, rxs, rxd, txs, rdata, irq}
        vt.push_back(mk(1, 0, 32'h00, 0, 0, 8'h00, 0, 32'hFFFF_F000, 0));
        vt.push_back(mk(1, 0, 32'h04, 0, 0, 8'h00, 0, 32'hFFFF_F000, 0));
        vt.push_back(mk(1, 0, 32'h08, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h1C, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h0C, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 1, 32'h00, 32'h1234_5678, 0, 8'h00, 0, 32'hFFFF_F000, 0));
        vt.push_back(mk(1, 0, 32'h00, 0, 0, 8'h00, 0, 32'h1234_5678, 0));
        vt.push_back(mk(0, 0, 32'h00, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(0, 1, 32'h20, 32'h8, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h8, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 1, 8'h41, 0, 32'h8, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'hA, 1));
        vt.push_back(mk(1, 0, 32'h1C, 0, 0, 8'h00, 0, 32'h41, 1));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h8, 0));
        vt.push_back(mk(0, 0, 32'h00, 0, 1, 8'h41, 0, 32'h0, 0));
        vt.push_back(mk(0, 0, 32'h00, 0, 1, 8'h42, 0, 32'h0, 1));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'hE, 1));
        vt.push_back(mk(1, 0, 32'h1C, 0, 0, 8'h00, 0, 32'h42, 1));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'hC, 0));
        vt.push_back(mk(0, 1, 32'h20, 32'h4, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(0, 0, 32'h00, 0, 1, 8'h41, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h1C, 0, 1, 8'h55, 0, 32'h41, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h2, 0));
        vt.push_back(mk(1, 0, 32'h1C, 0, 0, 8'h00, 0, 32'h55, 0));
        vt.push_back(mk(0, 1, 32'h18, 32'h5A, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 1, 32'h18, 32'h33, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h1, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 1, 32'h1, 0));
        vt.push_back(mk(1, 0, 32'h20, 0, 0, 8'h00, 0, 32'h0, 0));
        vt.push_back(mk(1, 0, 32'h04, 0, 0, 8'h00, 0, 32'hFFFF_F000, 0));

        txen_count = 0;
        foreach (vt[i]) begin
            tick(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rxs, vt[i].rxd, vt[i].txs);
            check($sformatf("vec%0d_rdata", i), last_rdata, vt[i].exp_rdata);
            check($sformatf("vec%0d_irq", i), 32'(last_irq), 32'(vt[i].exp_irq));
        end
        check("tx_pulse_count", txen_count, 1);
        check("tx_data_kept", 32'(last_txd), 32'h5A);

        // Write while uart_tx is busy is dropped
        txen_count = 0;
        tick(0, 1, 32'h18, 32'h77, 0, 8'h00, 1);
        idle();
        idle();
        check("tx_busy_drop_count", txen_count, 0);
        check("tx_busy_drop_data", 32'(last_txd), 32'h5A);

        // Timer overflow latency from reset values
        do_reset();
        tick(0, 1, 32'h08, 32'h3, 0, 8'h00, 0);
        j = 0;
        while (irqout !== 1'b1 && j < 32'h1100) begin
            idle();
            j++;
        end
        check("timer_irq_latency", j, 32'h1000);
        tick(1, 0, 32'h04, 0, 0, 8'h00, 0);
        check("timer_reload_tl", last_rdata, 32'hFFFF_F000);

        // Wrap without irq_en
        do_reset();
        tick(0, 1, 32'h04, 32'hFFFF_FFFF, 0, 8'h00, 0);
        tick(0, 1, 32'h08, 32'h1, 0, 8'h00, 0);
        idle();
        tick(1, 0, 32'h04, 0, 0, 8'h00, 0);
        check("wrap_tl", last_rdata, 32'hFFFF_F000);
        check("wrap_irq", 32'(last_irq), 32'h0);
        tick(1, 0, 32'h08, 0, 0, 8'h00, 0);
        check("wrap_tcon", last_rdata, 32'h1);

        // TCON write clearing b2 in the overflow cycle: set wins
        do_reset();
        tick(0, 1, 32'h04, 32'hFFFF_FFFE, 0, 8'h00, 0);
        tick(0, 1, 32'h08, 32'h3, 0, 8'h00, 0);
        idle();
        tick(0, 1, 32'h08, 32'h3, 0, 8'h00, 0);
        check("ovf_race_irq", 32'(irqout), 32'h1);
        tick(1, 0, 32'h08, 0, 0, 8'h00, 0);
        check("ovf_race_tcon", last_rdata, 32'h7);
        tick(0, 1, 32'h08, 32'h3, 0, 8'h00, 0);
        tick(1, 0, 32'h08, 0, 0, 8'h00, 0);
        check("tcon_clear_b2", last_rdata, 32'h3);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            a = (32'($urandom_range(0, 3)) << 30) | (32'($urandom_range(0, 9)) << 2)
                | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       d = 32'($urandom_range(0, 15));
                default: d = $urandom();
            endcase
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, d,
                 ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
